matrix_seq_unit: RTL

MATRIX_SEQ_UNIT -- requirements
Module: matrix_seq_unit

---
 rtl/matrix_pkg.sv | 32 +++
 rtl/elem_alu.sv | 51 +++++
 rtl/matrix_seq_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants for the matrix sequencer: opcodes, states, field positions.
package matrix_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_TRN = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;

    localparam int OP_LSB  = 0;
    localparam int OP_W    = 3;
    localparam int SAT_BIT = 3;
    localparam int SCL_LSB = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_TRN) || (op == OP_NEG);
    endfunction

    function automatic logic op_dual(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/elem_alu.sv
// One result element: signed arithmetic at double width, then wrap or clamp.
module elem_alu
    import matrix_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic [ELEM_W-1:0] scalar,
    input  logic [2:0]        opcode,
    input  logic              sat,
    output logic [ELEM_W-1:0] r,
    output logic              ovf
);

    localparam int WW = 2 * ELEM_W;
    localparam logic signed [WW-1:0] MAXV =
        {{(ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV =
        {{(ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};

    logic signed [WW-1:0] ax;
    logic signed [WW-1:0] bx;
    logic signed [WW-1:0] sx;
    logic signed [WW-1:0] wide;

    assign ax = {{ELEM_W{a[ELEM_W-1]}}, a};
    assign bx = {{ELEM_W{b[ELEM_W-1]}}, b};
    assign sx = {{ELEM_W{scalar[ELEM_W-1]}}, scalar};

    // transpose and unused opcodes pass A through unchanged
    always_comb begin
        wide = ax;
        case (opcode)
            OP_ADD:  wide = ax + bx;
            OP_SUB:  wide = ax - bx;
            OP_MUL:  wide = ax * sx;
            OP_NEG:  wide = -ax;
            default: wide = ax;
        endcase
    end

    always_comb begin
        ovf = (wide > MAXV) || (wide < MINV);
        r   = wide[ELEM_W-1:0];
        if (ovf && sat) begin
            r = wide[WW-1] ? MINV[ELEM_W-1:0] : MAXV[ELEM_W-1:0];
        end
    end

endmodule

// File: rtl/matrix_seq_unit.sv
// Fetches an instruction and operand matrices row by row, then writes
// the element-wise result back one row per cycle.
module matrix_seq_unit
    import matrix_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5,
    parameter int ADDR_W = $clog2(3*DIM+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ovf,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wren,
    output logic [DIM*ELEM_W-1:0] mem_wdata,
    input  logic [DIM*ELEM_W-1:0] mem_rdata
);

    localparam int ROW_W = DIM * ELEM_W;
    localparam logic [ADDR_W-1:0] RES_BASE = ADDR_W'(2*DIM+1);

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;
    logic [ADDR_W-1:0] cap_idx;
    logic [ADDR_W-1:0] fetch_last;
    logic              capture;
    logic [2:0]        op_now;

    logic [ROW_W-1:0]  a_q [DIM];
    logic [ROW_W-1:0]  b_q [DIM];
    logic [2:0]        op_q;
    logic              sat_q;
    logic [ELEM_W-1:0] scalar_q;
    logic              err_q;
    logic              ovf_q;

    logic [ROW_W-1:0]  a_row;
    logic [ROW_W-1:0]  b_row;
    logic [ROW_W-1:0]  tr_row;
    logic [ROW_W-1:0]  op_row;
    logic [ROW_W-1:0]  res_row;
    logic [DIM-1:0]    row_ovf;

    // read data lags the address by one cycle, so row cnt-1 lands now
    assign capture = ((state == S_FETCH) && (cnt != '0)) ||
                     (state == S_DRAIN);
    assign cap_idx = cnt - ADDR_W'(1);

    // the opcode is usable in the same cycle the instruction word arrives
    assign op_now = ((state == S_FETCH) && (cnt == ADDR_W'(1))) ?
                    mem_rdata[OP_LSB +: OP_W] : op_q;
    assign fetch_last = op_dual(op_now) ? ADDR_W'(2*DIM) : ADDR_W'(DIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FETCH;
                    cnt_nx   = '0;
                end
            end
            S_FETCH: begin
                cnt_nx = cnt + ADDR_W'(1);
                if ((cnt == ADDR_W'(1)) && !op_legal(op_now)) begin
                    state_nx = S_DONE;
                end else if (cnt == fetch_last) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nx = S_WRITE;
                cnt_nx   = '0;
            end
            S_WRITE: begin
                cnt_nx = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(DIM-1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DIM; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            op_q     <= '0;
            sat_q    <= 1'b0;
            scalar_q <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                err_q <= 1'b0;
                ovf_q <= 1'b0;
            end
            if (capture && (cap_idx == '0)) begin
                op_q     <= mem_rdata[OP_LSB +: OP_W];
                sat_q    <= mem_rdata[SAT_BIT];
                scalar_q <= mem_rdata[SCL_LSB +: ELEM_W];
            end
            for (int k = 0; k < DIM; k++) begin
                if (capture && (cap_idx == ADDR_W'(k+1))) begin
                    a_q[k] <= mem_rdata;
                end
                if (capture && (cap_idx == ADDR_W'(DIM+k+1))) begin
                    b_q[k] <= mem_rdata;
                end
            end
            if ((state == S_FETCH) && (cnt == ADDR_W'(1)) &&
                !op_legal(op_now)) begin
                err_q <= 1'b1;
            end
            if (state == S_WRITE) begin
                ovf_q <= ovf_q | (|row_ovf);
            end
        end
    end

    always_comb begin
        a_row  = '0;
        b_row  = '0;
        tr_row = '0;
        for (int k = 0; k < DIM; k++) begin
            if (cnt == ADDR_W'(k)) begin
                a_row = a_q[k];
                b_row = b_q[k];
                for (int j = 0; j < DIM; j++) begin
                    tr_row[(DIM-j)*ELEM_W-1 -: ELEM_W] =
                        a_q[j][(DIM-k)*ELEM_W-1 -: ELEM_W];
                end
            end
        end
    end

    assign op_row = (op_q == OP_TRN) ? tr_row : a_row;

    for (genvar j = 0; j < DIM; j++) begin : g_alu
        elem_alu #(
            .ELEM_W (ELEM_W)
        ) u_alu (
            .a      (op_row[(DIM-j)*ELEM_W-1 -: ELEM_W]),
            .b      (b_row[(DIM-j)*ELEM_W-1 -: ELEM_W]),
            .scalar (scalar_q),
            .opcode (op_q),
            .sat    (sat_q),
            .r      (res_row[(DIM-j)*ELEM_W-1 -: ELEM_W]),
            .ovf    (row_ovf[j])
        );
    end

    always_comb begin
        mem_addr  = '0;
        mem_wren  = 1'b0;
        mem_wdata = '0;
        case (state)
            S_FETCH: mem_addr = cnt;
            S_WRITE: begin
                mem_addr  = RES_BASE + cnt;
                mem_wren  = 1'b1;
                mem_wdata = res_row;
            end
            default: mem_addr = '0;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = err_q;
    assign ovf  = ovf_q;

endmodule
